// File: rtl/stage3_writeback.sv
// Writeback stage: buffers stage results in a small FIFO and streams them into a
// six-bank SRAM, one bank per pipe stage, with per-bank sequential addressing.
module stage3_writeback #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12
) (
    input  logic                      CLK_i,
    input  logic                      RST_ni,
    input  logic                      valid_i,
    input  logic [2:0]                stage_i,
    input  logic [WIDTH-1:0]          operand1_i,
    input  logic [WIDTH-1:0]          operand2_i,
    input  logic                      finished_i,
    input  logic                      clear_i,
    output logic                      stall_o,
    output logic                      sram_req_o,
    input  logic                      sram_gnt_i,
    output logic [2:0]                sram_bank_o,
    output logic [ADDR_W-1:0]         sram_addr_o,
    output logic [2*WIDTH-1:0]        sram_wdata_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic                      overflow_o,
    output logic                      done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [2:0]       stage;
        logic [WIDTH-1:0] op2;
        logic [WIDTH-1:0] op1;
    } entry_t;

    state_t            state_q;
    state_t            state_d;

    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;

    logic [ADDR_W-1:0] addr_cnt_q;
    logic [ADDR_W-1:0] addr_used;
    logic [2:0]        last_stage_q;
    logic              overflow_q;

    logic              full;
    logic              empty;
    logic              stage_ok;
    logic              accepting;
    logic              push;
    logic              pop;

    assign full      = (count_q == FULL_CNT);
    assign empty     = (count_q == '0);
    assign stage_ok  = (stage_i != 3'd0) && (stage_i != 3'd7);
    assign accepting = (state_q == IDLE) || (state_q == RUN);
    assign push      = valid_i && stage_ok && !full && accepting;

    assign head       = mem[rd_ptr_q];
    assign sram_req_o = !empty && ((state_q == RUN) || (state_q == DRAIN));
    assign pop        = sram_req_o && sram_gnt_i;

    // A new stage restarts its bank at address 0; a repeat stage continues.
    assign addr_used = (head.stage != last_stage_q) ? '0 : addr_cnt_q;

    assign stall_o    = full;
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign done_o     = (state_q == DONE);

    // Head fields are only presented while a request is up, so idle outputs are 0.
    always_comb begin
        sram_bank_o  = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        if (sram_req_o) begin
            sram_bank_o = head.stage - 3'd1;
            sram_addr_o = addr_used;
            if (head.stage == 3'd6) begin
                sram_wdata_o = {head.op2, head.op1};
            end else begin
                sram_wdata_o = {{WIDTH{1'b0}}, head.op1};
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (push)        state_d = RUN;
            RUN:     if (finished_i)  state_d = DRAIN;
            DRAIN:   if (empty)       state_d = DONE;
            DONE:    if (clear_i)     state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the pointers and
    // count, which are reset, so clearing the array would only cost flops.
    always_ff @(posedge CLK_i) begin
        if (push) begin
            mem[wr_ptr_q] <= '{stage: stage_i, op2: operand2_i, op1: operand1_i};
        end
    end

    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Address counter wraps naturally; the wrapping pop latches the sticky flag.
    always_ff @(posedge CLK_i or negedge RST_ni) begin
        if (!RST_ni) begin
            addr_cnt_q   <= '0;
            last_stage_q <= '0;
            overflow_q   <= 1'b0;
        end else if (pop) begin
            addr_cnt_q   <= addr_used + 1'b1;
            last_stage_q <= head.stage;
            if (&addr_used) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_stage3_writeback.sv
// Directed bench for stage3_writeback: a per-cycle vector table for the basic
// flows plus hand-written sequences for address wrap and reset mid-drain.
module tb_stage3_writeback;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 12;
    localparam int NVEC   = 33;

    logic              CLK_i;
    logic              RST_ni;
    logic              valid_i;
    logic [2:0]        stage_i;
    logic [15:0]       operand1_i;
    logic [15:0]       operand2_i;
    logic              finished_i;
    logic              clear_i;
    logic              stall_o;
    logic              sram_req_o;
    logic              sram_gnt_i;
    logic [2:0]        sram_bank_o;
    logic [11:0]       sram_addr_o;
    logic [31:0]       sram_wdata_o;
    logic [2:0]        count_o;
    logic              overflow_o;
    logic              done_o;

    int n_checks = 0;
    int n_fail   = 0;

    stage3_writeback #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK_i        (CLK_i),
        .RST_ni       (RST_ni),
        .valid_i      (valid_i),
        .stage_i      (stage_i),
        .operand1_i   (operand1_i),
        .operand2_i   (operand2_i),
        .finished_i   (finished_i),
        .clear_i      (clear_i),
        .stall_o      (stall_o),
        .sram_req_o   (sram_req_o),
        .sram_gnt_i   (sram_gnt_i),
        .sram_bank_o  (sram_bank_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .count_o      (count_o),
        .overflow_o   (overflow_o),
        .done_o       (done_o)
    );

    initial CLK_i = 1'b0;
    always #5 CLK_i = ~CLK_i;

    // Inputs presented during one cycle, and the outputs expected in that same cycle
    // (outputs reflect state from earlier edges only).
    typedef struct {
        logic        valid;
        logic [2:0]  stage;
        logic [15:0] op1;
        logic [15:0] op2;
        logic        fin;
        logic        clr;
        logic        gnt;
        logic        req;
        logic [2:0]  bank;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [2:0]  cnt;
        logic        stall;
        logic        done;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(
        input logic v, input logic [2:0] st, input logic [15:0] o1, input logic [15:0] o2,
        input logic fin, input logic clr, input logic gnt,
        input logic req, input logic [2:0] bank, input logic [11:0] addr,
        input logic [31:0] wd, input logic [2:0] cnt, input logic stall, input logic done);
        vec_t r;
        r.valid = v;   r.stage = st;  r.op1 = o1;   r.op2 = o2;
        r.fin   = fin; r.clr   = clr; r.gnt = gnt;
        r.req   = req; r.bank  = bank; r.addr = addr; r.wdata = wd;
        r.cnt   = cnt; r.stall = stall; r.done = done;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] st, input logic [15:0] o1,
                         input logic [15:0] o2, input logic fin, input logic clr,
                         input logic gnt);
        valid_i    = v;
        stage_i    = st;
        operand1_i = o1;
        operand2_i = o2;
        finished_i = fin;
        clear_i    = clr;
        sram_gnt_i = gnt;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".req"},   64'(sram_req_o),   64'h0);
        check({tag, ".cnt"},   64'(count_o),      64'h0);
        check({tag, ".stall"}, 64'(stall_o),      64'h0);
        check({tag, ".done"},  64'(done_o),       64'h0);
        check({tag, ".ovf"},   64'(overflow_o),   64'h0);
        check({tag, ".bank"},  64'(sram_bank_o),  64'h0);
        check({tag, ".addr"},  64'(sram_addr_o),  64'h0);
        check({tag, ".wdata"}, 64'(sram_wdata_o), 64'h0);
    endtask

    initial begin
        int pops;
        logic [11:0] last_addr;

        // Stage-1 burst
        vecs[0]  = mk(1, 1, 16'h3C00, 0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[1]  = mk(1, 1, 16'h4000, 0, 0, 0, 1,  1, 0, 0, 32'h0000_3C00, 1, 0, 0);
        vecs[2]  = mk(1, 1, 16'h4200, 0, 0, 0, 1,  1, 0, 1, 32'h0000_4000, 1, 0, 0);
        vecs[3]  = mk(0, 0, 16'h0,    0, 0, 0, 1,  1, 0, 2, 32'h0000_4200, 1, 0, 0);
        vecs[4]  = mk(0, 0, 16'h0,    0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        // Backpressure: fill to 4, fifth dropped, push refused while full even with a pop
        vecs[5]  = mk(1, 2, 16'h0001, 0, 0, 0, 0,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[6]  = mk(1, 2, 16'h0002, 0, 0, 0, 0,  1, 1, 0, 32'h0000_0001, 1, 0, 0);
        vecs[7]  = mk(1, 2, 16'h0003, 0, 0, 0, 0,  1, 1, 0, 32'h0000_0001, 2, 0, 0);
        vecs[8]  = mk(1, 2, 16'h0004, 0, 0, 0, 0,  1, 1, 0, 32'h0000_0001, 3, 0, 0);
        vecs[9]  = mk(1, 2, 16'h0005, 0, 0, 0, 0,  1, 1, 0, 32'h0000_0001, 4, 1, 0);
        vecs[10] = mk(0, 0, 16'h0,    0, 0, 0, 0,  1, 1, 0, 32'h0000_0001, 4, 1, 0);
        vecs[11] = mk(1, 2, 16'h0009, 0, 0, 0, 1,  1, 1, 0, 32'h0000_0001, 4, 1, 0);
        vecs[12] = mk(0, 0, 16'h0,    0, 0, 0, 1,  1, 1, 1, 32'h0000_0002, 3, 0, 0);
        vecs[13] = mk(0, 0, 16'h0,    0, 0, 0, 1,  1, 1, 2, 32'h0000_0003, 2, 0, 0);
        vecs[14] = mk(0, 0, 16'h0,    0, 0, 0, 1,  1, 1, 3, 32'h0000_0004, 1, 0, 0);
        vecs[15] = mk(0, 0, 16'h0,    0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        // Stage change 5 -> 6, with the stage-6 packed write
        vecs[16] = mk(1, 5, 16'h0A00, 0,        0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[17] = mk(1, 5, 16'h0A01, 0,        0, 0, 1,  1, 4, 0, 32'h0000_0A00, 1, 0, 0);
        vecs[18] = mk(1, 6, 16'h0012, 16'h1000, 0, 0, 1,  1, 4, 1, 32'h0000_0A01, 1, 0, 0);
        vecs[19] = mk(0, 0, 16'h0,    0,        0, 0, 1,  1, 5, 0, 32'h1000_0012, 1, 0, 0);
        // Stages 0 and 7 discarded; operand2 masked for stage 3
        vecs[20] = mk(1, 0, 16'h1111, 16'h2222, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[21] = mk(1, 7, 16'h3333, 16'h4444, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[22] = mk(1, 3, 16'h1234, 16'hBEEF, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[23] = mk(0, 0, 16'h0,    0,        0, 0, 1,  1, 2, 0, 32'h0000_1234, 1, 0, 0);
        vecs[24] = mk(0, 0, 16'h0,    0,        0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        // Finish: clear ignored in RUN, drain two, valid ignored in DRAIN/DONE, clear
        vecs[25] = mk(1, 1, 16'h0101, 0, 0, 1, 0,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[26] = mk(1, 1, 16'h0102, 0, 0, 0, 0,  1, 0, 0, 32'h0000_0101, 1, 0, 0);
        vecs[27] = mk(0, 0, 16'h0,    0, 1, 0, 1,  1, 0, 0, 32'h0000_0101, 2, 0, 0);
        vecs[28] = mk(1, 1, 16'h0555, 0, 0, 0, 1,  1, 0, 1, 32'h0000_0102, 1, 0, 0);
        vecs[29] = mk(1, 1, 16'h0666, 0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);
        vecs[30] = mk(1, 2, 16'h0777, 0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 1);
        vecs[31] = mk(0, 0, 16'h0,    0, 0, 1, 1,  0, 0, 0, 32'h0,        0, 0, 1);
        vecs[32] = mk(0, 0, 16'h0,    0, 0, 0, 1,  0, 0, 0, 32'h0,        0, 0, 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        RST_ni = 1'b0;
        #1;
        check_idle_outputs("reset");
        @(negedge CLK_i);
        RST_ni = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            @(negedge CLK_i);
            drive(vecs[i].valid, vecs[i].stage, vecs[i].op1, vecs[i].op2,
                  vecs[i].fin, vecs[i].clr, vecs[i].gnt);
            #1;
            check({tag, ".req"},   64'(sram_req_o),  64'(vecs[i].req));
            check({tag, ".bank"},  64'(sram_bank_o), 64'(vecs[i].bank));
            check({tag, ".addr"},  64'(sram_addr_o), 64'(vecs[i].addr));
            check({tag, ".wdata"}, 64'(sram_wdata_o), 64'(vecs[i].wdata));
            check({tag, ".cnt"},   64'(count_o),     64'(vecs[i].cnt));
            check({tag, ".stall"}, 64'(stall_o),     64'(vecs[i].stall));
            check({tag, ".done"},  64'(done_o),      64'(vecs[i].done));
            check({tag, ".ovf"},   64'(overflow_o),  64'h0);
        end

        // Address wrap: 4097 stage-3 writes streamed back to back
        pops = 0;
        last_addr = '1;
        for (int c = 0; c < 4100; c++) begin
            @(negedge CLK_i);
            if (c < 4097) drive(1, 3, 16'(c), 16'hFFFF, 0, 0, 1);
            else          drive(0, 0, 0, 0, 0, 0, 1);
            #1;
            if (sram_req_o) begin
                check("wrap.addr",  64'(sram_addr_o),  64'(pops % 4096));
                check("wrap.wdata", 64'(sram_wdata_o), 64'({16'h0, 16'(pops)}));
                check("wrap.bank",  64'(sram_bank_o),  64'h2);
                check("wrap.ovf",   64'(overflow_o),   64'(pops >= 4096));
                last_addr = sram_addr_o;
                pops++;
            end
        end
        check("wrap.pops",      64'(pops),       64'd4097);
        check("wrap.last_addr", 64'(last_addr),  64'h0);
        check("wrap.ovf_held",  64'(overflow_o), 64'h1);

        // Reset mid-drain with three entries buffered
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK_i);
            drive(1, 4, 16'(16'h0700 + k), 0, 0, 0, 0);
        end
        @(negedge CLK_i);
        drive(0, 0, 0, 0, 1, 0, 0);
        #1;
        check("drain.cnt", 64'(count_o),    64'h3);
        check("drain.req", 64'(sram_req_o), 64'h1);
        @(negedge CLK_i);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        check("drain.req2", 64'(sram_req_o), 64'h1);
        check("drain.ovf",  64'(overflow_o), 64'h1);
        check("drain.done", 64'(done_o),     64'h0);
        #2;
        RST_ni = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge CLK_i);
        RST_ni = 1'b1;
        sram_gnt_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK_i);
            #1;
            check($sformatf("postrst%0d.req", k), 64'(sram_req_o), 64'h0);
            check($sformatf("postrst%0d.cnt", k), 64'(count_o),    64'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage3_writeback.md
STAGE3_WRITEBACK -- requirements
Module: stage3_writeback

Interface
REQ-001 Parameter WIDTH, default 16, fp16 operand width.
REQ-002 Parameter DEPTH, default 4, entries in the internal FIFO (power of two, >=2).
REQ-003 Parameter ADDR_W, default 12, SRAM word-address width (n=4096 words per bank).
REQ-004 CLK_i  in  1  sole clock, all state updates on rising edge.
REQ-005 RST_ni  in  1  reset, asynchronous and active-low.
REQ-006 valid_i  in  1  upstream pipe stage result valid this cycle.
REQ-007 stage_i  in  3  upstream stage number for the offered result.
REQ-008 operand1_i  in  WIDTH  upstream operand1 (value or center_ids).
REQ-009 operand2_i  in  WIDTH  upstream operand2 (dnorm, meaningful in stage 6 only).
REQ-010 finished_i  in  1  upstream finished flag.
REQ-011 clear_i  in  1  synchronous return from DONE to IDLE.
REQ-012 stall_o  out  1  backpressure to upstream, drives its stall input.
REQ-013 sram_req_o  out  1  SRAM write request.
REQ-014 sram_gnt_i  in  1  SRAM accepts the request this cycle.
REQ-015 sram_bank_o  out  3  target bank 0..5.
REQ-016 sram_addr_o  out  ADDR_W  word address within bank.
REQ-017 sram_wdata_o  out  2*WIDTH  write data.
REQ-018 count_o  out  clog2(DEPTH)+1  current FIFO occupancy.
REQ-019 overflow_o  out  1  sticky, address wrapped in some bank.
REQ-020 done_o  out  1  all results written after finished.

Function
REQ-021 FSM states IDLE, RUN, DRAIN, DONE; encoding free.
REQ-022 Accept (push) SHALL occur when valid_i=1, stage_i in 1..6, FIFO not full, and state is IDLE or RUN; entries with stage_i 0 or 7 are discarded without push.
REQ-023 stall_o SHALL equal FIFO-full, combinational from registered count.
REQ-024 IDLE->RUN on first accepted push; RUN->DRAIN on the cycle finished_i=1 is sampled; DRAIN->DONE when FIFO empty and no request outstanding; DONE->IDLE when clear_i=1.
REQ-025 In DRAIN and DONE, valid_i SHALL be ignored (no push).
REQ-026 FIFO entry = {stage_i, operand2_i, operand1_i}; registered storage; an entry pushed at edge t is visible on sram_* outputs after edge t (earliest request cycle t+1).
REQ-027 sram_req_o = FIFO non-empty and state in {RUN, DRAIN}; outputs driven from the head entry and held stable while sram_gnt_i=0.
REQ-028 Pop on sram_req_o & sram_gnt_i; simultaneous push and pop when not full leaves count unchanged; when full, push is refused even if a pop occurs the same cycle.
REQ-029 sram_bank_o = head stage - 1.
REQ-030 sram_wdata_o = {operand2, operand1} when head stage = 6, else {WIDTH'h0, operand1}.
REQ-031 Address counter: on each pop, if head stage differs from last-written stage, address used is 0 and counter becomes 1; otherwise address used is counter value and counter increments.
REQ-032 Counter wraps 2^ADDR_W-1 -> 0; the pop that causes wrap sets overflow_o, which stays 1 until reset.
REQ-033 done_o = 1 exactly while state is DONE.
REQ-034 clear_i outside DONE SHALL have no effect.

Reset
REQ-035 On RST_ni=0, asynchronously: state IDLE, FIFO empty, count_o 0, stall_o 0, sram_req_o 0, address counter 0, last-written stage 0, overflow_o 0, done_o 0; sram_bank_o/addr/wdata 0.
REQ-036 Reset mid-operation SHALL drop all buffered entries with no further SRAM requests; release is synchronous to the next CLK_i edge.

Verification
REQ-037 Stage-1 burst: 3 pushes operand1=0x3C00,0x4000,0x4200, gnt=1 -> writes bank 0 addr 0,1,2, wdata upper half 0.
REQ-038 Backpressure: gnt=0, 5 valid pushes stage 2 -> count_o=4, stall_o=1, 5th dropped; gnt=1 -> 4 writes bank 1 addr 0..3, stall_o falls after first pop.
REQ-039 Stage change: 2 entries stage 5 then 1 entry stage 6 {0x1000,0x0012} -> bank 4 addr 0,1, then bank 5 addr 0, wdata 0x10000012.
REQ-040 Wrap: 4097 stage-3 writes -> last address 0, overflow_o=1 and held.
REQ-041 Finish: 2 entries buffered, finished_i=1, gnt=1 -> both written, done_o=1 next cycle after FIFO empty; valid_i in DONE ignored; clear_i -> IDLE.
REQ-042 Reset mid-drain: RST_ni low with 3 entries buffered -> immediately sram_req_o=0, count_o=0, no writes after release.
